// File: rtl/lpc_frame_scheduler.sv
// LPC frame scheduler: loads one audio frame into the encoder, starts it, then streams
// ORDER coefficients followed by FRAME_LEN residues. Optional WAIT timeout: LPC_SCHED_TIMEOUT_EN.
module lpc_frame_scheduler #(
    parameter int FRAME_LEN = 160,
    parameter int ORDER     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             x_wen,
    output logic [7:0]       x_waddr,
    output logic [15:0]      x_din,
    output logic             start,
    input  logic             rready,
    output logic [ORDER-1:0] a_rsel,
    input  logic [31:0]      a_dout,
    output logic [7:0]       residue_raddr,
    input  logic [15:0]      residue_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_kind,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             err
);

    localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [KW-1:0]    LAST_K   = KW'(ORDER - 1);
    localparam logic [KW-1:0]    K_ONE    = KW'(1);
    localparam logic [ORDER-1:0] SEL_ONE  = ORDER'(1);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        COEF  = 3'd3,
        RES   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t           state_r;
    logic [7:0]       idx_r;
    logic [KW-1:0]    k_r;
    logic [7:0]       j_r;
    logic [15:0]      frame_count_r;
    logic             in_ready_r;
    logic             start_r;
    logic [ORDER-1:0] a_rsel_r;
    logic             out_valid_r;
    logic             out_kind_r;
    logic             out_last_r;
    logic             busy_r;
    logic             first_wait_r;
    logic [31:0]      out_data_s;
`ifdef LPC_SCHED_TIMEOUT_EN
    logic [15:0]      wait_cnt_r;
    logic             err_r;
`endif

    // Sequencer: state, counters and all registered control outputs move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= LOAD;
            idx_r         <= 8'd0;
            k_r           <= '0;
            j_r           <= 8'd0;
            frame_count_r <= 16'd0;
            in_ready_r    <= 1'b1;
            start_r       <= 1'b0;
            a_rsel_r      <= '0;
            out_valid_r   <= 1'b0;
            out_kind_r    <= 1'b0;
            out_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            first_wait_r  <= 1'b0;
`ifdef LPC_SCHED_TIMEOUT_EN
            wait_cnt_r    <= 16'd0;
            err_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_valid) begin
                        if (idx_r == LAST_IDX) begin
                            idx_r      <= 8'd0;
                            in_ready_r <= 1'b0;
                            start_r    <= 1'b1;
                            busy_r     <= 1'b1;
                            state_r    <= START;
                        end else begin
                            idx_r <= idx_r + 8'd1;
                        end
                    end
                end
                START: begin
                    start_r      <= 1'b0;
                    first_wait_r <= 1'b1;
`ifdef LPC_SCHED_TIMEOUT_EN
                    wait_cnt_r   <= 16'd0;
`endif
                    state_r      <= WAIT;
                end
                WAIT: begin
                    // The encoder's done level may still be left over from the last frame.
                    if (first_wait_r) begin
                        first_wait_r <= 1'b0;
                    end
                    if (!first_wait_r && rready) begin
                        a_rsel_r    <= SEL_ONE;
                        out_valid_r <= 1'b1;
                        out_kind_r  <= 1'b0;
                        out_last_r  <= 1'b0;
                        state_r     <= COEF;
                    end
`ifdef LPC_SCHED_TIMEOUT_EN
                    else if (wait_cnt_r == 16'hFFFE) begin
                        wait_cnt_r <= 16'hFFFF;
                        err_r      <= 1'b1;
                        state_r    <= ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
`endif
                end
                COEF: begin
                    if (out_ready) begin
                        if (k_r == LAST_K) begin
                            k_r        <= '0;
                            a_rsel_r   <= '0;
                            out_kind_r <= 1'b1;
                            out_last_r <= (LAST_IDX == 8'd0);
                            state_r    <= RES;
                        end else begin
                            k_r      <= k_r + K_ONE;
                            a_rsel_r <= a_rsel_r << 1;
                        end
                    end
                end
                RES: begin
                    if (out_ready) begin
                        if (j_r == LAST_IDX) begin
                            j_r           <= 8'd0;
                            out_valid_r   <= 1'b0;
                            out_kind_r    <= 1'b0;
                            out_last_r    <= 1'b0;
                            in_ready_r    <= 1'b1;
                            busy_r        <= 1'b0;
                            frame_count_r <= frame_count_r + 16'd1;
                            state_r       <= LOAD;
                        end else begin
                            j_r        <= j_r + 8'd1;
                            out_last_r <= ((j_r + 8'd1) == LAST_IDX);
                        end
                    end
                end
                ERR: begin
                    in_ready_r  <= 1'b0;
                    start_r     <= 1'b0;
                    a_rsel_r    <= '0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b1;
                    state_r     <= ERR;
                end
                default: begin
                    idx_r       <= 8'd0;
                    k_r         <= '0;
                    j_r         <= 8'd0;
                    in_ready_r  <= 1'b1;
                    start_r     <= 1'b0;
                    a_rsel_r    <= '0;
                    out_valid_r <= 1'b0;
                    out_kind_r  <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= LOAD;
                end
            endcase
        end
    end

    // Result data is a pass-through of the addressed memory, widened for residues.
    always_comb begin
        out_data_s = 32'd0;
        if (out_valid_r) begin
            if (out_kind_r) begin
                out_data_s = {{16{residue_dout[15]}}, residue_dout};
            end else begin
                out_data_s = a_dout;
            end
        end else begin
            out_data_s = 32'd0;
        end
    end

    // in_ready is only high in LOAD, so it also gates the audio write strobe.
    assign x_wen         = in_ready_r & in_valid;
    assign x_waddr       = idx_r;
    assign x_din         = in_data;
    assign in_ready      = in_ready_r;
    assign start         = start_r;
    assign a_rsel        = a_rsel_r;
    assign residue_raddr = j_r;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_s;
    assign out_kind      = out_kind_r;
    assign out_last      = out_last_r;
    assign busy          = busy_r;
    assign frame_count   = frame_count_r;
`ifdef LPC_SCHED_TIMEOUT_EN
    assign err           = err_r;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: doc/lpc_frame_scheduler.md
LPC_FRAME_SCHEDULER -- requirements
Module: lpc_frame_scheduler

Interface
REQ-001 SHALL have parameters: FRAME_LEN, default 160, samples per frame; ORDER, default 10, number of LPC coefficients.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 16): audio sample stream.
REQ-005 SHALL have ports x_wen (output, 1), x_waddr (output, 8) and x_din (output, 16): encoder audio write channel.
REQ-006 SHALL have ports start (output, 1) and rready (input, 1): encoder start pulse and done level.
REQ-007 SHALL have ports a_rsel (output, 10, one-hot) and a_dout (input, 32): coefficient read; data is valid in the same cycle as the select.
REQ-008 SHALL have ports residue_raddr (output, 8) and residue_dout (input, 16): residue read; data is valid in the same cycle as the address.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32), out_kind (output, 1; 0=coef, 1=residue) and out_last (output, 1): result stream.
REQ-010 SHALL have ports busy (output, 1), frame_count (output, 16) and err (output, 1): status.

Function
REQ-011 SHALL implement the states LOAD, START, WAIT, COEF, RES and ERR.
REQ-012 LOAD: in_ready=1; when in_valid is high, x_wen=1, x_waddr=sample index, x_din=in_data, and the index increments.
REQ-013 LOAD: on the write of index FRAME_LEN-1, the index clears and the block moves to START.
REQ-014 START: start=1 for exactly one cycle, then WAIT.
REQ-015 WAIT: rready is ignored in the first WAIT cycle; afterwards rready=1 moves the block to COEF.
REQ-016 COEF: a_rsel = one-hot bit k; out_data=a_dout; out_kind=0; out_valid=1; k advances only when out_valid and out_ready are both high.
REQ-017 COEF: after the transfer of k=ORDER-1, the block moves to RES.
REQ-018 RES: residue_raddr=j; out_data=residue_dout sign-extended to 32 bits; out_kind=1; out_valid=1.
REQ-019 RES: out_last=1 only at j=FRAME_LEN-1; after that transfer the block moves to LOAD and frame_count increments, wrapping at 16'hFFFF to 0.
REQ-020 out_data, out_kind and out_last SHALL be held stable while out_valid=1 and out_ready=0 (backpressure).
REQ-021 Outside their owning state: x_wen=0, start=0, a_rsel=0, residue_raddr=0, out_valid=0, out_last=0, in_ready=0.
REQ-022 busy SHALL be 1 in every state except LOAD.
REQ-023 in_valid in any state other than LOAD SHALL not be consumed (in_ready=0; no x write).

Reset
REQ-024 reset SHALL force state=LOAD, sample index=0, k=0, j=0, frame_count=0, err=0, and every output to its REQ-021 idle value; in_ready=1 in the following cycle.
REQ-025 reset asserted mid-frame in any state SHALL abandon the frame: no start pulse is issued, and the partial stream is not completed.

Configuration
REQ-026 With macro LPC_SCHED_TIMEOUT_EN defined: a 16-bit counter runs in WAIT; if it reaches 16'hFFFF without rready, the block enters ERR with err=1, and stays there until reset.
REQ-027 Without LPC_SCHED_TIMEOUT_EN: no counter exists, WAIT persists indefinitely, ERR is unreachable and err is tied to 0.

Verification
REQ-028 Push 160 samples 0..159 with in_valid held high -> 160 x_wen cycles with addresses 0..159, then a single-cycle start one cycle after the last write.
REQ-029 Raise rready 5 cycles after start with out_ready=1 -> 10 coef beats with a_rsel 0x001..0x200, then 160 residue beats; out_last on beat 170; frame_count=1.
REQ-030 Residue value 16'h8001 -> out_data=32'hFFFF8001 with out_kind=1.
REQ-031 Toggle out_ready 1/0 every cycle during COEF -> each beat is held while stalled, and exactly 10 coef beats occur with no duplicates.
REQ-032 Assert reset during RES at j=50 -> next cycle is LOAD, frame_count=0, out_valid=0; a following full frame completes normally.
REQ-033 With LPC_SCHED_TIMEOUT_EN defined and rready held at 0 -> err=1 after 65535 WAIT cycles, and the block ignores in_valid until reset.
